fwd_hazard_ctrl: RTL and testbench

- Control block for the 5-stage pipeline that drives the select lines of the EX-stage operand forwarding muxes.
- Detects load-use hazards and generates stall and bubble controls.
- Flushes younger stages on a taken branch.
- Keeps its own shadow copy of ID/EX, EX/MEM and MEM/WB destination-register state, plus saturating stall/flush performance counters.

---
 rtl/fwd_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select, load-use stall and branch-flush control for a
// 5-stage in-order pipeline. Tracks its own shadow of the ID/EX, EX/MEM
// and MEM/WB destination-register state and keeps saturating stall/flush
// performance counters.
module fwd_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_rec_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } dst_rec_t;

    ex_rec_t  ex_q;
    dst_rec_t mem_q;
    dst_rec_t wb_q;

    logic     load_use_c;
    logic     mem_wr_c;
    logic     wb_wr_c;

    // Load-use detection against the load currently in EX.
    always_comb begin
        load_use_c = 1'b0;
        if (ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
            (ex_q.rd != '0) && id_valid) begin
            load_use_c = (id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_q.rd));
        end
    end

    // Stall/bubble/flush; a taken branch overrides any load-use stall.
    always_comb begin
        stall       = 1'b0;
        bubble_ex   = 1'b0;
        flush_if_id = 1'b0;
        if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end else if (load_use_c) begin
            stall       = 1'b1;
            bubble_ex   = 1'b1;
        end
    end

    // A producer is eligible only if it is real, writes, and is not x0.
    always_comb begin
        mem_wr_c = mem_q.valid && mem_q.reg_write && (mem_q.rd != '0);
        wb_wr_c  = wb_q.valid  && wb_q.reg_write  && (wb_q.rd  != '0);
    end

    // Operand forwarding selects; MEM (younger producer) beats WB.
    always_comb begin
        fwd_a_sel = SEL_RF;
        fwd_b_sel = SEL_RF;
        if (ex_q.valid && ex_q.use_rs1) begin
            if (mem_wr_c && (mem_q.rd == ex_q.rs1)) begin
                fwd_a_sel = SEL_MEM;
            end else if (wb_wr_c && (wb_q.rd == ex_q.rs1)) begin
                fwd_a_sel = SEL_WB;
            end
        end
        if (ex_q.valid && ex_q.use_rs2) begin
            if (mem_wr_c && (mem_q.rd == ex_q.rs2)) begin
                fwd_b_sel = SEL_MEM;
            end else if (wb_wr_c && (wb_q.rd == ex_q.rs2)) begin
                fwd_b_sel = SEL_WB;
            end
        end
    end

    // Shadow pipeline advance; a bubble loads an invalid EX record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= '{valid:     ex_q.valid,
                       rd:        ex_q.rd,
                       reg_write: ex_q.reg_write};
            if (bubble_ex) begin
                ex_q <= '0;
            end else begin
                ex_q <= '{valid:     id_valid,
                          rs1:       id_rs1,
                          rs2:       id_rs2,
                          use_rs1:   id_use_rs1,
                          use_rs2:   id_use_rs2,
                          rd:        id_rd,
                          reg_write: id_reg_write,
                          mem_read:  id_mem_read};
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (ex_branch_taken && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, hand sequences for reset
// and counter saturation, and randomized traffic against a reference model.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic       ex_branch_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, bubble_ex, flush_if_id;
    logic [15:0] stall_cnt, flush_cnt;

    logic       sat_br;
    logic [1:0] sat_fa, sat_fb;
    logic       sat_stall, sat_bubble, sat_flush;
    logic [3:0] sat_stall_cnt, sat_flush_cnt;

    int n_checks;
    int n_fail;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .id_valid(1'b0), .id_rs1(5'd0), .id_rs2(5'd0),
        .id_use_rs1(1'b0), .id_use_rs2(1'b0), .id_rd(5'd0),
        .id_reg_write(1'b0), .id_mem_read(1'b0),
        .ex_branch_taken(sat_br),
        .fwd_a_sel(sat_fa), .fwd_b_sel(sat_fb),
        .stall(sat_stall), .bubble_ex(sat_bubble), .flush_if_id(sat_flush),
        .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    typedef struct {
        instr_t id;
        bit     br;
        int     fa;
        int     fb;
        bit     st;
        bit     bu;
        bit     fl;
    } vec_t;

    // Reference model: instructions in flight, index 0=EX, 1=MEM, 2=WB.
    instr_t inflight[3];
    int     m_stall_cnt;
    int     m_flush_cnt;
    localparam int CNT_MAX = 65535;

    function automatic instr_t ins(bit v, int rs1, int rs2, bit u1, bit u2,
                                   int rd, bit rw, bit mr);
        instr_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
        t.rd = rd; t.rw = rw; t.mr = mr;
        return t;
    endfunction

    function automatic instr_t nop();
        return ins(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t vec(instr_t id, bit br, int fa, int fb,
                                 bit st, bit bu, bit fl);
        vec_t t;
        t.id = id; t.br = br; t.fa = fa; t.fb = fb;
        t.st = st; t.bu = bu; t.fl = fl;
        return t;
    endfunction

    // Youngest eligible producer older than EX supplies the operand.
    function automatic int model_fwd(int src, bit use_src);
        if (!inflight[0].v || !use_src) return 0;
        for (int s = 1; s <= 2; s++) begin
            if (inflight[s].v && inflight[s].rw && inflight[s].rd != 0 &&
                inflight[s].rd == src)
                return (s == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit model_load_use(instr_t id);
        instr_t e;
        e = inflight[0];
        if (!(e.v && e.mr && e.rw && e.rd != 0 && id.v)) return 0;
        return (id.u1 && id.rs1 == e.rd) || (id.u2 && id.rs2 == e.rd);
    endfunction

    function automatic vec_t model_expect(instr_t id, bit br);
        bit lu;
        lu = model_load_use(id);
        return vec(id, br, model_fwd(inflight[0].rs1, inflight[0].u1),
                   model_fwd(inflight[0].rs2, inflight[0].u2),
                   lu && !br, lu || br, br);
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) inflight[s] = nop();
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic model_advance(instr_t id, bit br);
        bit lu;
        lu = model_load_use(id);
        if (lu && !br && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (br && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        inflight[2] = inflight[1];
        inflight[1] = inflight[0];
        inflight[0] = (lu || br) ? nop() : id;
    endtask

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(instr_t id, bit br);
        id_valid        = id.v;
        id_rs1          = 5'(id.rs1);
        id_rs2          = 5'(id.rs2);
        id_use_rs1      = id.u1;
        id_use_rs2      = id.u2;
        id_rd           = 5'(id.rd);
        id_reg_write    = id.rw;
        id_mem_read     = id.mr;
        ex_branch_taken = br;
    endtask

    // One cycle: drive after negedge, check settled outputs, clock, advance model.
    task automatic run_cycle(vec_t v, string tag);
        drive(v.id, v.br);
        #1;
        check({tag, ".fwd_a_sel"}, int'(fwd_a_sel), v.fa);
        check({tag, ".fwd_b_sel"}, int'(fwd_b_sel), v.fb);
        check({tag, ".stall"}, int'(stall), int'(v.st));
        check({tag, ".bubble_ex"}, int'(bubble_ex), int'(v.bu));
        check({tag, ".flush_if_id"}, int'(flush_if_id), int'(v.fl));
        @(posedge clk);
        model_advance(v.id, v.br);
        @(negedge clk);
    endtask

    task automatic check_counters(string tag);
        check({tag, ".stall_cnt"}, int'(stall_cnt), m_stall_cnt);
        check({tag, ".flush_cnt"}, int'(flush_cnt), m_flush_cnt);
    endtask

    vec_t   tbl[$];
    instr_t lw7;
    instr_t use7;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sat_br   = 1'b0;
        rst_n    = 1'b0;
        drive(nop(), 0);
        model_clear();
        repeat (2) @(negedge clk);
        check("reset.fwd_a_sel", int'(fwd_a_sel), 0);
        check("reset.fwd_b_sel", int'(fwd_b_sel), 0);
        check("reset.stall", int'(stall), 0);
        check("reset.bubble_ex", int'(bubble_ex), 0);
        check("reset.flush_if_id", int'(flush_if_id), 0);
        check_counters("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: {ID instr, branch, fa, fb, stall, bubble, flush}
        tbl.push_back(vec(ins(1,1,2,1,1,5,1,0), 0, 0,0,0,0,0)); // add x5,x1,x2
        tbl.push_back(vec(ins(1,5,1,1,1,6,1,0), 0, 0,0,0,0,0)); // sub x6,x5,x1
        tbl.push_back(vec(nop(),                0, 2,0,0,0,0)); // sub in EX: MEM fwd
        tbl.push_back(vec(ins(1,1,2,1,1,5,1,0), 0, 0,0,0,0,0)); // add x5
        tbl.push_back(vec(ins(1,7,8,1,1,9,1,0), 0, 0,0,0,0,0)); // unrelated or x9
        tbl.push_back(vec(ins(1,5,1,1,1,6,1,0), 0, 0,0,0,0,0)); // sub x6,x5,x1
        tbl.push_back(vec(nop(),                0, 1,0,0,0,0)); // sub in EX: WB fwd
        tbl.push_back(vec(ins(1,1,0,1,0,3,1,0), 0, 0,0,0,0,0)); // addi x3
        tbl.push_back(vec(ins(1,1,0,1,0,3,1,0), 0, 0,0,0,0,0)); // addi x3
        tbl.push_back(vec(ins(1,2,3,1,1,4,1,0), 0, 0,0,0,0,0)); // add x4,x2,x3
        tbl.push_back(vec(nop(),                0, 0,2,0,0,0)); // double producer
        tbl.push_back(vec(ins(1,1,0,1,0,7,1,1), 0, 0,0,0,0,0)); // lw x7
        tbl.push_back(vec(ins(1,7,2,1,1,8,1,0), 0, 0,0,1,1,0)); // load-use stall
        tbl.push_back(vec(ins(1,7,2,1,1,8,1,0), 0, 0,0,0,0,0)); // held: bubble in EX
        tbl.push_back(vec(nop(),                0, 1,0,0,0,0)); // load result via WB
        tbl.push_back(vec(ins(1,1,0,1,0,0,1,1), 0, 0,0,0,0,0)); // lw x0
        tbl.push_back(vec(ins(1,0,0,1,1,9,1,0), 0, 0,0,0,0,0)); // reads x0: no stall
        tbl.push_back(vec(ins(1,1,0,1,0,7,1,1), 0, 0,0,0,0,0)); // lw x7; rd=0 no fwd
        tbl.push_back(vec(ins(1,7,2,0,1,10,1,0),0, 0,0,0,0,0)); // rs1 unused: no stall
        tbl.push_back(vec(ins(1,1,0,1,0,7,1,1), 0, 0,0,0,0,0)); // lw x7; unused rs1 no fwd
        tbl.push_back(vec(ins(1,7,2,1,1,8,1,0), 1, 0,0,0,1,1)); // branch beats stall
        tbl.push_back(vec(nop(),                0, 0,0,0,0,0));
        foreach (tbl[i]) run_cycle(tbl[i], $sformatf("vec%0d", i));
        check_counters("table");
        check("table.stall_cnt_abs", int'(stall_cnt), 1);
        check("table.flush_cnt_abs", int'(flush_cnt), 1);

        // Randomized traffic with a small register space to provoke matches.
        for (int n = 0; n < 400; n++) begin
            instr_t id;
            bit     br;
            id = ins($urandom_range(0, 5) != 0,
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3),
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            br = ($urandom_range(0, 9) == 0);
            run_cycle(model_expect(id, br), $sformatf("rnd%0d", n));
            if (n % 50 == 49) check_counters($sformatf("rnd%0d", n));
        end

        // Reset mid-stream with a pending load-use match.
        lw7  = ins(1,1,0,1,0,7,1,1);
        use7 = ins(1,7,0,1,0,8,1,0);
        run_cycle(model_expect(lw7, 0), "pre_rst_lw");
        drive(use7, 0);
        #1;
        check("pre_rst.stall", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst.fwd_a_sel", int'(fwd_a_sel), 0);
        check("mid_rst.fwd_b_sel", int'(fwd_b_sel), 0);
        check("mid_rst.stall", int'(stall), 0);
        check("mid_rst.bubble_ex", int'(bubble_ex), 0);
        check("mid_rst.flush_if_id", int'(flush_if_id), 0);
        model_clear();
        check_counters("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(vec(use7, 0, 0,0,0,0,0), "post_rst");
        check_counters("post_rst");

        // Saturation on the 4-bit counter instance.
        sat_br = 1'b1;
        repeat (20) @(negedge clk);
        check("sat.flush_if_id", int'(sat_flush), 1);
        check("sat.flush_cnt", int'(sat_flush_cnt), 15);
        check("sat.stall_cnt", int'(sat_stall_cnt), 0);
        sat_br = 1'b0;
        @(negedge clk);
        check("sat.flush_cnt_hold", int'(sat_flush_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
